// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: word width, opcodes and fetch FSM encoding.
package cpu_pkg;

    localparam int WORD_W = 16;

    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DRAIN,
        S_HALT
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [3:0] opcode_of(input logic [WORD_W-1:0] instr);
        return instr[WORD_W-1 -: 4];
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry shift FIFO of fetched {pc, instr}; entry 0 is always the head so the
// head view comes straight from registers.
module fetch_buffer
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    logic         vld0_q;
    logic         vld1_q;
    fetch_entry_t ent0_q;
    fetch_entry_t ent1_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld0_q <= 1'b0;
            vld1_q <= 1'b0;
        end else begin
            case ({push, pop})
                2'b01: begin
                    vld0_q <= vld1_q;
                    vld1_q <= 1'b0;
                end
                2'b10: begin
                    if (vld0_q) vld1_q <= 1'b1;
                    else        vld0_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Simultaneous push and pop keeps occupancy; only the data shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_q <= '0;
        end else if (!flush) begin
            if (pop && vld1_q)
                ent0_q <= ent1_q;
            else if (push && (pop || !vld0_q))
                ent0_q <= push_entry;
            if (push && ((vld0_q && !pop) || (vld1_q && pop)))
                ent1_q <= push_entry;
        end
    end

    assign full  = vld1_q;
    assign empty = ~vld0_q;
    assign head  = ent0_q;

    push_into_full: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !flush && vld1_q));

endmodule

// File: rtl/prefetch_unit.sv
// Instruction-fetch front end: PC register, single-outstanding imem handshake,
// 2-entry fetch queue, branch redirect and halt handling.
module prefetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
    parameter logic [3:0]        HLT_OP   = OP_HLT,
    parameter logic [WORD_W-1:0] PC_INC   = 16'd2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_data,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              stall,
    output logic              id_valid,
    output logic [WORD_W-1:0] id_instr,
    output logic [WORD_W-1:0] id_pc,
    output logic [WORD_W-1:0] id_pc_plus2,
    output logic [WORD_W-1:0] pc_out,
    output logic              hlt
);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic              halt_pend_q, halt_pend_d;
    logic              hlt_q, hlt_d;

    logic              buf_push, buf_pop, buf_flush;
    logic              buf_full, buf_empty;
    fetch_entry_t      buf_head, push_entry;

    logic [WORD_W-1:0] pc_inc;
    logic              room_no_push, room_after_push;
    logic              data_is_hlt, hlt_accept;

    fetch_buffer u_fetch_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (buf_push),
        .pop        (buf_pop),
        .flush      (buf_flush),
        .push_entry (push_entry),
        .full       (buf_full),
        .empty      (buf_empty),
        .head       (buf_head)
    );

    assign id_valid = ~buf_empty & (state_q != S_HALT);
    assign buf_pop  = id_valid & ~stall;

    // A slot freed by this cycle's pop is usable for the next request.
    assign room_no_push    = ~buf_full | buf_pop;
    assign room_after_push = buf_empty | (~buf_full & buf_pop);

    assign pc_inc      = pc_q + PC_INC;
    assign data_is_hlt = (opcode_of(imem_data) == HLT_OP);
    assign hlt_accept  = buf_pop & (opcode_of(buf_head.instr) == HLT_OP);

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        addr_d           = addr_q;
        req_d            = req_q;
        halt_pend_d      = halt_pend_q;
        hlt_d            = hlt_q;
        buf_push         = 1'b0;
        buf_flush        = 1'b0;
        push_entry.pc    = addr_q;
        push_entry.instr = imem_data;

        // Redirect flushes regardless of stall and cancels any speculative halt.
        if (redirect && state_q != S_HALT) begin
            buf_flush   = 1'b1;
            halt_pend_d = 1'b0;
            pc_d        = redirect_pc;
        end

        case (state_q)
            S_FETCH: begin
                if (!redirect) begin
                    if (hlt_accept) begin
                        state_d = S_HALT;
                        hlt_d   = 1'b1;
                    end else if (!halt_pend_q && room_no_push) begin
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    if (redirect) begin
                        req_d   = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        buf_push    = 1'b1;
                        pc_d        = pc_inc;
                        halt_pend_d = halt_pend_q | data_is_hlt;
                        // Back-to-back: keep req high and move straight to the next address.
                        if (!(halt_pend_q || data_is_hlt) && room_after_push) begin
                            addr_d = pc_inc;
                        end else begin
                            req_d   = 1'b0;
                            state_d = S_FETCH;
                        end
                    end
                end else if (redirect) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                req_d = 1'b0;
            end
            default: begin
                state_d = S_FETCH;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            req_q       <= 1'b0;
            halt_pend_q <= 1'b0;
            hlt_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            req_q       <= req_d;
            halt_pend_q <= halt_pend_d;
            hlt_q       <= hlt_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign pc_out      = pc_q;
    assign hlt         = hlt_q;
    assign id_instr    = buf_head.instr;
    assign id_pc       = buf_head.pc;
    assign id_pc_plus2 = buf_head.pc + PC_INC;

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: latency-programmable memory model, decode-side
// acceptance log, and hand-computed expected values.
module tb_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        stall = 1'b0;
    logic        id_valid;
    logic [15:0] id_instr, id_pc, id_pc_plus2, pc_out;
    logic        hlt;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    int          mem_lat = 1;
    logic [15:0] hlt_addr = 16'h0001;
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [15:0] mem_addr_q = 16'h0;

    logic [15:0] acc_pc[$];
    logic [15:0] acc_in[$];
    logic [15:0] acc_p2[$];
    int          acc_cyc[$];
    logic [15:0] req_log[$];

    prefetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus2 (id_pc_plus2),
        .pc_out      (pc_out),
        .hlt         (hlt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == hlt_addr) ? 16'hF000 : {4'h1, a[11:0]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mem_busy <= 1'b0;
            imem_ack <= 1'b0;
        end else if (imem_ack) begin
            imem_ack <= 1'b0;
            mem_busy <= 1'b0;
        end else if (mem_busy) begin
            if (mem_cnt == 1) begin
                imem_ack  <= 1'b1;
                imem_data <= mem_word(mem_addr_q);
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end else if (imem_req) begin
            mem_busy   <= 1'b1;
            mem_addr_q <= imem_addr;
            req_log.push_back(imem_addr);
            if (mem_lat == 1) begin
                imem_ack  <= 1'b1;
                imem_data <= mem_word(imem_addr);
            end else begin
                mem_cnt <= mem_lat - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && id_valid && !stall) begin
            acc_pc.push_back(id_pc);
            acc_in.push_back(id_instr);
            acc_p2.push_back(id_pc_plus2);
            acc_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        acc_pc.delete();
        acc_in.delete();
        acc_p2.delete();
        acc_cyc.delete();
        req_log.delete();
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        stall    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_acc(input string tag, input int n);
        for (int i = 0; i < 300 && acc_pc.size() < n; i++) @(negedge clk);
        chk(tag, 16'(acc_pc.size() >= n), 16'd1);
    endtask

    task automatic pulse_redirect(input logic [15:0] tgt);
        redirect    = 1'b1;
        redirect_pc = tgt;
        @(negedge clk);
        redirect = 1'b0;
    endtask

    initial begin
        int          k;
        logic [15:0] held_pc, held_in;

        // Reset values, sampled while rst is held.
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", 16'(imem_req), 16'd0);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_pc_out", pc_out, 16'h0000);
        chk("rst_id_valid", 16'(id_valid), 16'd0);
        chk("rst_id_instr", id_instr, 16'h0000);
        chk("rst_id_pc", id_pc, 16'h0000);
        chk("rst_id_pc_plus2", id_pc_plus2, 16'h0002);
        chk("rst_hlt", 16'(hlt), 16'd0);

        // Sequential fetch, 1-cycle memory, no stall.
        mem_lat = 1;
        apply_reset();
        wait_acc("t1_acc", 3);
        chk("t1_pc0", acc_pc[0], 16'h0000);
        chk("t1_pc1", acc_pc[1], 16'h0002);
        chk("t1_pc2", acc_pc[2], 16'h0004);
        chk("t1_in0", acc_in[0], 16'h1000);
        chk("t1_in2", acc_in[2], 16'h1004);
        chk("t1_p2_0", acc_p2[0], 16'h0002);
        chk("t1_p2_2", acc_p2[2], 16'h0006);

        // Stall with 3-cycle memory: queue fills, requests stop, head held.
        mem_lat = 3;
        apply_reset();
        stall = 1'b1;
        repeat (12) @(negedge clk);
        held_pc = id_pc;
        held_in = id_instr;
        repeat (8) @(negedge clk);
        chk("t2_req_idle", 16'(imem_req), 16'd0);
        chk("t2_req_cnt", 16'(req_log.size()), 16'd2);
        chk("t2_pc_out", pc_out, 16'h0004);
        chk("t2_valid", 16'(id_valid), 16'd1);
        chk("t2_id_pc", id_pc, 16'h0000);
        chk("t2_id_in", id_instr, 16'h1000);
        chk("t2_stable_pc", held_pc, 16'h0000);
        chk("t2_stable_in", held_in, 16'h1000);
        stall = 1'b0;
        wait_acc("t2_acc", 4);
        chk("t2_pc0", acc_pc[0], 16'h0000);
        chk("t2_pc1", acc_pc[1], 16'h0002);
        chk("t2_pc2", acc_pc[2], 16'h0004);
        chk("t2_pc3", acc_pc[3], 16'h0006);

        // Redirect while waiting on 0x0006.
        mem_lat = 4;
        apply_reset();
        k = 0;
        while (k < 200 && !(imem_req && imem_addr == 16'h0006 && !imem_ack)) begin
            @(negedge clk);
            k++;
        end
        chk("t3_reach", 16'(k < 200), 16'd1);
        pulse_redirect(16'h0100);
        chk("t3_req_held", 16'(imem_req), 16'd1);
        chk("t3_addr_held", imem_addr, 16'h0006);
        chk("t3_pc_out", pc_out, 16'h0100);
        chk("t3_flushed", 16'(id_valid), 16'd0);
        wait_acc("t3_acc", 5);
        chk("t3_pc2", acc_pc[2], 16'h0004);
        chk("t3_pc3", acc_pc[3], 16'h0100);
        chk("t3_pc4", acc_pc[4], 16'h0102);
        chk("t3_in3", acc_in[3], 16'h1100);
        chk("t3_req3", req_log[3], 16'h0006);
        chk("t3_req4", req_log[4], 16'h0100);

        // Redirect in the same cycle as the ack of 0x0002.
        mem_lat = 2;
        apply_reset();
        k = 0;
        while (k < 200 && !(imem_ack && imem_addr == 16'h0002)) begin
            @(negedge clk);
            k++;
        end
        chk("t4_reach", 16'(k < 200), 16'd1);
        pulse_redirect(16'h0040);
        chk("t4_req_drop", 16'(imem_req), 16'd0);
        chk("t4_pc_out", pc_out, 16'h0040);
        chk("t4_valid", 16'(id_valid), 16'd0);
        @(negedge clk);
        chk("t4_next_req", 16'(imem_req), 16'd1);
        chk("t4_next_addr", imem_addr, 16'h0040);
        wait_acc("t4_acc", 2);
        chk("t4_pc0", acc_pc[0], 16'h0000);
        chk("t4_pc1", acc_pc[1], 16'h0040);

        // HLT at 0x0008 reaches decode and halts the unit.
        mem_lat  = 1;
        hlt_addr = 16'h0008;
        apply_reset();
        k = 0;
        while (k < 200 && !hlt) begin
            @(negedge clk);
            k++;
        end
        chk("t5_hlt", 16'(hlt), 16'd1);
        chk("t5_last_pc", acc_pc[acc_pc.size()-1], 16'h0008);
        chk("t5_last_in", acc_in[acc_in.size()-1], 16'hF000);
        chk("t5_hlt_lag", 16'(cyc - acc_cyc[acc_cyc.size()-1]), 16'd1);
        chk("t5_req_cnt", 16'(req_log.size()), 16'd5);
        pulse_redirect(16'h0200);
        repeat (10) @(negedge clk);
        chk("t5_req_cnt_after", 16'(req_log.size()), 16'd5);
        chk("t5_req_off", 16'(imem_req), 16'd0);
        chk("t5_valid_off", 16'(id_valid), 16'd0);
        chk("t5_pc_kept", pc_out, 16'h000A);
        chk("t5_hlt_sticky", 16'(hlt), 16'd1);

        // HLT queued under stall, then cancelled by a redirect.
        apply_reset();
        k = 0;
        while (k < 200 && !(imem_ack && imem_addr == 16'h0008)) begin
            @(negedge clk);
            k++;
        end
        chk("t5b_reach", 16'(k < 200), 16'd1);
        stall = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5b_req_off", 16'(imem_req), 16'd0);
        chk("t5b_head_pc", id_pc, 16'h0008);
        chk("t5b_head_in", id_instr, 16'hF000);
        chk("t5b_no_hlt", 16'(hlt), 16'd0);
        pulse_redirect(16'h0020);
        chk("t5b_flushed", 16'(id_valid), 16'd0);
        chk("t5b_pc_out", pc_out, 16'h0020);
        stall = 1'b0;
        wait_acc("t5b_acc", 6);
        chk("t5b_pc4", acc_pc[4], 16'h0020);
        chk("t5b_pc5", acc_pc[5], 16'h0022);
        chk("t5b_hlt_clear", 16'(hlt), 16'd0);
        hlt_addr = 16'h0001;

        // PC wrap-around from 0xFFFE.
        apply_reset();
        stall = 1'b1;
        repeat (15) @(negedge clk);
        chk("t6_idle", 16'(imem_req), 16'd0);
        pulse_redirect(16'hFFFE);
        clear_logs();
        stall = 1'b0;
        wait_acc("t6_acc", 3);
        chk("t6_pc0", acc_pc[0], 16'hFFFE);
        chk("t6_pc1", acc_pc[1], 16'h0000);
        chk("t6_pc2", acc_pc[2], 16'h0002);
        chk("t6_p2_0", acc_p2[0], 16'h0000);
        chk("t6_req0", req_log[0], 16'hFFFE);
        chk("t6_req1", req_log[1], 16'h0000);

        // Reset while a request is outstanding.
        mem_lat = 5;
        k = 0;
        while (k < 200 && !(imem_req && imem_addr == 16'h000A)) begin
            @(negedge clk);
            k++;
        end
        chk("t6_reach_wait", 16'(k < 200), 16'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_req", 16'(imem_req), 16'd0);
        chk("t6_rst_pc_out", pc_out, 16'h0000);
        chk("t6_rst_addr", imem_addr, 16'h0000);
        chk("t6_rst_valid", 16'(id_valid), 16'd0);
        rst = 1'b0;
        clear_logs();
        wait_acc("t6_restart", 1);
        chk("t6_restart_pc", acc_pc[0], 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
